// File: rtl/instr_sequencer_ctrl_pkg.sv
// Shared definitions for the instruction sequencer:
// opcodes, ALU op codes, FSM states, instruction fields.
package instr_sequencer_ctrl_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ABS  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_ABS = 2'b10;

  localparam int F_OPC_HI = 15;
  localparam int F_OPC_LO = 13;
  localparam int F_IMM    = 12;
  localparam int F_DST_HI = 10;
  localparam int F_DST_LO = 8;
  localparam int F_VAL_HI = 7;
  localparam int F_VAL_LO = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_HI,
    S_FETCH_LO,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_WRITEBACK,
    S_HALTED,
    S_ERROR
  } state_e;

endpackage

// File: rtl/instr_seq_regfile.sv
// 8x8 register file: two combinational read ports,
// one synchronous write port, plus a tap on reg[0].
module instr_seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [2:0] wa_i,
  input  logic [7:0] wd_i,
  input  logic [2:0] ra_a_i,
  input  logic [2:0] ra_b_i,
  output logic [7:0] rd_a_o,
  output logic [7:0] rd_b_o,
  output logic [7:0] r0_o
);

  logic [7:0] mem_q [8];

  // Storage: cleared on reset, written on we_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = mem_q[ra_a_i];
  assign rd_b_o = mem_q[ra_b_i];
  assign r0_o   = mem_q[0];

endmodule

// File: rtl/instr_sequencer_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator
// datapath with an external start/done ALU.
module instr_sequencer_ctrl
  import instr_sequencer_ctrl_pkg::*;
#(
  parameter int PC_W        = 4,
  parameter int PROG_LEN    = 4,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  output logic            fetch_req,
  output logic [PC_W:0]   fetch_addr,
  input  logic            fetch_valid,
  input  logic [7:0]      fetch_data,
  output logic            alu_start,
  output logic [1:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic            alu_done,
  input  logic [7:0]      alu_result,
  input  logic            alu_ovf,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic [7:0]      al_out,
  output logic            ovf_flag
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ALU_TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_LAST =
    PC_W'(PROG_LEN - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [7:0]      val_q, val_d;
  logic            vovf_q, vovf_d;
  logic            we;

  logic [2:0] opc;
  logic       imm_sel;
  logic [2:0] dst;
  logic [7:0] imm;
  logic [7:0] rd_a, rd_b, operand;

  assign opc     = ir_q[F_OPC_HI:F_OPC_LO];
  assign imm_sel = ir_q[F_IMM];
  assign dst     = ir_q[F_DST_HI:F_DST_LO];
  assign imm     = ir_q[F_VAL_HI:F_VAL_LO];
  assign operand = imm_sel ? imm : rd_b;

  instr_seq_regfile u_rf (
    .clk    (CLK),
    .rst_n  (RESET),
    .we_i   (we),
    .wa_i   (dst),
    .wd_i   (val_q),
    .ra_a_i (dst),
    .ra_b_i (imm[2:0]),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .r0_o   (al_out)
  );

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      val_q   <= '0;
      vovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      val_q   <= val_d;
      vovf_q  <= vovf_d;
    end
  end

  // Next-state logic, decode and ALU dispatch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    val_d   = val_q;
    vovf_d  = vovf_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH_HI;
          pc_d    = '0;
          ir_d    = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH_HI: begin
        if (fetch_valid) begin
          ir_d[15:8] = fetch_data;
          state_d    = S_FETCH_LO;
        end
      end
      S_FETCH_LO: begin
        if (fetch_valid) begin
          ir_d[7:0] = fetch_data;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opc)
          OP_MOV: begin
            val_d   = operand;
            vovf_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_WRITEBACK;
          end
          OP_ADD: begin
            op_d    = ALU_ADD;
            a_d     = rd_a;
            b_d     = operand;
            state_d = S_EXEC;
          end
          OP_SUB: begin
            op_d    = ALU_SUB;
            a_d     = rd_a;
            b_d     = operand;
            state_d = S_EXEC;
          end
          OP_ABS: begin
            op_d    = ALU_ABS;
            a_d     = rd_a;
            b_d     = '0;
            state_d = S_EXEC;
          end
          OP_HALT: state_d = S_HALTED;
          default: state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        cnt_d   = '0;
        state_d = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          val_d   = alu_result;
          vovf_d  = alu_ovf;
          state_d = S_WRITEBACK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        we    = 1'b1;
        ovf_d = vovf_q;
        if (pc_q == PC_LAST) begin
          state_d = S_HALTED;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fetch_req = (state_q == S_FETCH_HI) ||
                     (state_q == S_FETCH_LO);
  assign fetch_addr =
    (state_q == S_FETCH_HI) ? {pc_q, 1'b0} :
    (state_q == S_FETCH_LO) ? {pc_q, 1'b1} : '0;
  assign alu_start = (state_q == S_EXEC);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign busy      = (state_q != S_IDLE) &&
                     (state_q != S_HALTED) &&
                     (state_q != S_ERROR);
  assign halted    = (state_q == S_HALTED);
  assign error     = (state_q == S_ERROR);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: doc/instr_sequencer_ctrl.md
Name: instr_sequencer_ctrl

Overview:
Sequencing controller for the 8-bit accumulator datapath. Fetches 16-bit instructions as two bytes (high byte first) from the machine-code byte source over a req/valid handshake, then decodes them. Each instruction executes against an internal 8x8 register file (index 0 = AL), with ADD/SUB/ABS dispatched to the external ALU over a start/done handshake. It halts after PROG_LEN instructions, on HALT, or on error.

Parameters:
PC_W, 4, instruction-counter width; fetch_addr is PC_W+1 bits (byte address = {pc, hi/lo}).
PROG_LEN, 4, number of instructions run before auto-halt (1..2^PC_W).
ALU_TIMEOUT, 15, max cycles in WAIT_ALU before ERROR.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; honoured only in IDLE, HALTED or ERROR; restarts at pc=0.
fetch_req  out  1  byte request, high in FETCH_HI/FETCH_LO.
fetch_addr  out  PC_W+1  {pc,1'b0} in FETCH_HI, {pc,1'b1} in FETCH_LO, else 0.
fetch_valid  in  1  fetch_data valid this cycle.
fetch_data  in  8  instruction byte.
alu_start  out  1  one-cycle pulse in EXEC.
alu_op  out  2  00 ADD, 01 SUB, 10 ABS.
alu_a  out  8  reg[dst].
alu_b  out  8  operand (0 for ABS).
alu_done  in  1  result valid; sampled only in WAIT_ALU.
alu_result  in  8  ALU result.
alu_ovf  in  1  ALU overflow, captured with alu_result.
busy  out  1  state not IDLE/HALTED/ERROR.
halted  out  1  state HALTED.
error  out  1  state ERROR.
pc  out  PC_W  current instruction index.
ir  out  16  current instruction register.
al_out  out  8  reg[0].
ovf_flag  out  1  overflow of last written ALU result; cleared by MOV.

Behaviour:
- Reset (async, RESET=0): state IDLE; pc, ir, all registers, ovf_flag, timeout counter = 0; all outputs 0.
- Instruction format: [15:13] opcode, [12] I (1 = immediate), [11] reserved (ignored), [10:8] dst, [7:0] imm. Operand = imm if I=1, else reg[imm[2:0]].
- Opcodes: 000 MOV, 001 ADD, 010 SUB, 011 ABS, 111 HALT; 100/101/110 illegal.
- IDLE: start -> FETCH_HI, pc=0.
- FETCH_HI: on fetch_valid, ir[15:8]<=fetch_data -> FETCH_LO. Waits indefinitely otherwise.
- FETCH_LO: on fetch_valid, ir[7:0]<=fetch_data -> DECODE.
- DECODE (1 cycle):
  - MOV -> WRITEBACK with value = operand, ovf_flag<=0.
  - ADD/SUB/ABS -> EXEC.
  - HALT -> HALTED; no writeback; pc unchanged.
  - illegal -> ERROR.
- EXEC (1 cycle): alu_start=1; alu_op, alu_a and alu_b are registered and held stable until ALU writeback -> WAIT_ALU, counter=0.
- WAIT_ALU:
  - alu_done=1: capture alu_result/alu_ovf -> WRITEBACK.
  - Otherwise counter+1; counter reaching ALU_TIMEOUT without done -> ERROR.
  - Minimum ALU latency is 1 cycle; alu_done in EXEC is ignored.
- WRITEBACK (1 cycle): reg[dst]<=value; ovf_flag updated. If pc==PROG_LEN-1 -> HALTED with pc held, else pc<=pc+1 -> FETCH_HI.
- Latency with zero-wait fetch and 1-cycle ALU, from entry into FETCH_HI to next FETCH_HI:
  - MOV: 4 cycles.
  - ALU op: 6 cycles.
- HALTED/ERROR are sticky until start or reset. Restart keeps register contents and clears ir.
- start while busy is ignored.
- Writes to dst=0 update al_out the cycle after WRITEBACK.
- Reading and writing the same register within one instruction uses the pre-write value.

Decomposition:
Shared package holds:
- opcode constants (OP_MOV, OP_ADD, OP_SUB, OP_ABS, OP_HALT);
- ALU op codes;
- state encoding (IDLE, FETCH_HI, FETCH_LO, DECODE, EXEC, WAIT_ALU, WRITEBACK, HALTED, ERROR);
- instruction field bit positions.

One sub-module: instr_seq_regfile, 8x8 with 2 combinational read ports, 1 synchronous write port, async active-low clear.

Test Plan:
- Program MOV AL,28; ADD AL,54; SUB AL,91; ABS AL, zero-wait fetch, 1-cycle ALU model -> al_out 9, halted=1, pc=3, ovf_flag=0, total 22 cycles from FETCH_HI.
- Same program with MOV AL,32 / ADD 16 / SUB 64 / ABS, with 3-cycle fetch_valid delay and 4-cycle ALU latency -> al_out 16, fetch_addr sequence 0..7 with each address held until valid.
- ALU never asserts done -> ERROR exactly ALU_TIMEOUT+1 cycles after alu_start; start then reruns from pc=0.
- Word 0x8000 (illegal opcode 100) at pc=1 -> ERROR after DECODE, no register write, pc=1.
- HALT (0xE000) at pc=0 -> halted=1, registers unchanged; register-operand ADD (I=0) uses reg[imm[2:0]] correctly.
- RESET asserted in WAIT_ALU -> all outputs 0 immediately (asynchronously); start after release executes normally.
